// File: rtl/sc_pkg.sv
// Shared single-cycle-processor datapath definitions: word/address widths and types
// used by the register file, the ALU and the ALUSrc mux.
package sc_pkg;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;

  typedef logic [ADDR_W-1:0] reg_addr_t;
  typedef logic [DATA_W-1:0] word_t;

  localparam reg_addr_t REG_ZERO = '0;
endpackage

// File: rtl/sc_regfile_read_port.sv
// One combinational register-file read port: index, r0 zero-forcing and, when
// SC_REGFILE_BYPASS_EN is defined, write-through bypass from the write port.
module sc_regfile_read_port
  import sc_pkg::*;
#(
  parameter int DATA_W   = sc_pkg::DATA_W,
  parameter int ADDR_W   = sc_pkg::ADDR_W,
  parameter int NUM_REGS = 2 ** ADDR_W
) (
  input  logic [DATA_W-1:0] regs [NUM_REGS],
  input  logic [ADDR_W-1:0] raddr,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

`ifndef SC_REGFILE_BYPASS_EN
  // Write-port inputs only matter to the bypass build.
  logic unused_write_port;
  assign unused_write_port = &{1'b0, we, waddr, wdata};
`endif

  always_comb begin
    rdata = regs[raddr];
`ifdef SC_REGFILE_BYPASS_EN
    if (we && (waddr != ADDR_W'(REG_ZERO)) && (waddr == raddr)) begin
      rdata = wdata;
    end
`endif
    if (raddr == ADDR_W'(REG_ZERO)) begin
      rdata = '0;
    end
  end

endmodule

// File: rtl/sc_register_file.sv
// Architectural register file for the single-cycle datapath: two combinational read
// ports, one write port, r0 hardwired to zero, saturating committed-write counter.
// Optional write-through bypass on the read ports: define SC_REGFILE_BYPASS_EN.
module sc_register_file
  import sc_pkg::*;
#(
  parameter int DATA_W   = sc_pkg::DATA_W,
  parameter int ADDR_W   = sc_pkg::ADDR_W,
  parameter int NUM_REGS = 2 ** ADDR_W,
  parameter int CNT_W    = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr_a,
  input  logic [ADDR_W-1:0] raddr_b,
  output logic [DATA_W-1:0] rdata_a,
  output logic [DATA_W-1:0] rdata_b,
  output logic [CNT_W-1:0]  wr_count
);

  logic [DATA_W-1:0]   reg_file_reg [NUM_REGS];
  logic [NUM_REGS-1:0] wr_sel;
  logic                commit;
  logic [CNT_W-1:0]    wr_count_reg;

  // Writes to r0 never commit, so r0 storage stays at its reset value of zero.
  assign commit = we && (waddr != ADDR_W'(REG_ZERO));

  generate
    for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_wr_sel
      assign wr_sel[gi] = commit && (waddr == ADDR_W'(gi));
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        reg_file_reg[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (wr_sel[i]) begin
          reg_file_reg[i] <= wdata;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_count_reg <= '0;
    end else if (commit && (wr_count_reg != {CNT_W{1'b1}})) begin
      wr_count_reg <= wr_count_reg + 1'b1;
    end
  end

  assign wr_count = wr_count_reg;

  sc_regfile_read_port #(
    .DATA_W   (DATA_W),
    .ADDR_W   (ADDR_W),
    .NUM_REGS (NUM_REGS)
  ) u_port_a (
    .regs  (reg_file_reg),
    .raddr (raddr_a),
    .we    (we),
    .waddr (waddr),
    .wdata (wdata),
    .rdata (rdata_a)
  );

  sc_regfile_read_port #(
    .DATA_W   (DATA_W),
    .ADDR_W   (ADDR_W),
    .NUM_REGS (NUM_REGS)
  ) u_port_b (
    .regs  (reg_file_reg),
    .raddr (raddr_b),
    .we    (we),
    .waddr (waddr),
    .wdata (wdata),
    .rdata (rdata_b)
  );

endmodule

// File: tb/tb_sc_register_file.sv
// Randomised self-checking bench for sc_register_file against an array-based model;
// a second instance with a 4-bit counter shares the stimulus to exercise saturation.
module tb_sc_register_file;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        we;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic [4:0]  raddr_a;
  logic [4:0]  raddr_b;
  logic [31:0] rdata_a, rdata_b, rdata_a_s, rdata_b_s;
  logic [15:0] wr_count;
  logic [3:0]  wr_count_s;

  int tests = 0;
  int fails = 0;

  logic [31:0] model [32];
  int cnt_big;
  int cnt_small;

  always #5 clk = ~clk;

  sc_register_file dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .we       (we),
    .waddr    (waddr),
    .wdata    (wdata),
    .raddr_a  (raddr_a),
    .raddr_b  (raddr_b),
    .rdata_a  (rdata_a),
    .rdata_b  (rdata_b),
    .wr_count (wr_count)
  );

  sc_register_file #(.CNT_W(4)) dut_small (
    .clk      (clk),
    .rst_n    (rst_n),
    .we       (we),
    .waddr    (waddr),
    .wdata    (wdata),
    .raddr_a  (raddr_a),
    .raddr_b  (raddr_b),
    .rdata_a  (rdata_a_s),
    .rdata_b  (rdata_b_s),
    .wr_count (wr_count_s)
  );

  task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    if (obs !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Expected read value derived from the architectural rules and current inputs.
  function automatic logic [31:0] exp_read(input logic [4:0] ra);
    if (ra == 5'd0) return 32'h0;
`ifdef SC_REGFILE_BYPASS_EN
    if (rst_n && we && waddr != 5'd0 && waddr == ra) return wdata;
`endif
    return model[ra];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) model[i] = 32'h0;
    cnt_big   = 0;
    cnt_small = 0;
  endtask

  task automatic check_all();
    check_value("rdata_a", rdata_a, exp_read(raddr_a));
    check_value("rdata_b", rdata_b, exp_read(raddr_b));
    check_value("rdata_a_small", rdata_a_s, exp_read(raddr_a));
    check_value("rdata_b_small", rdata_b_s, exp_read(raddr_b));
    check_value("wr_count", {16'h0, wr_count}, cnt_big);
    check_value("wr_count_small", {28'h0, wr_count_s}, cnt_small);
  endtask

  // One transaction: drive after the falling edge, check mid-cycle, commit at rising edge.
  task automatic step(input logic w, input logic [4:0] wa, input logic [31:0] wd,
                      input logic [4:0] ra, input logic [4:0] rb);
    @(negedge clk);
    we = w; waddr = wa; wdata = wd; raddr_a = ra; raddr_b = rb;
    #1;
    check_all();
    $display("[TB] we=%0d waddr=%0d wdata=%08h ra=%0d rb=%0d -> a=%08h b=%08h cnt=%0d cnt4=%0d",
             w, wa, wd, ra, rb, rdata_a, rdata_b, wr_count, wr_count_s);
    @(posedge clk);
    if (rst_n && w && wa != 5'd0) begin
      model[wa] = wd;
      if (cnt_big < 65535) cnt_big++;
      if (cnt_small < 15) cnt_small++;
    end
  endtask

  initial begin
    logic [31:0] alu_b;
    logic [4:0]  wa, ra, rb;

    rst_n = 1'b0; we = 1'b0; waddr = '0; wdata = '0; raddr_a = 5'd5; raddr_b = 5'd31;
    model_reset();
    #2;
    check_all();
    @(negedge clk);
    rst_n = 1'b1;

    // Preload r5, then assert reset mid-cycle with a write to r9 pending.
    step(1'b1, 5'd5, 32'h0000_1234, 5'd0, 5'd0);
    step(1'b0, 5'd0, 32'h0, 5'd5, 5'd5);
    @(negedge clk);
    raddr_a = 5'd5; raddr_b = 5'd9; we = 1'b1; waddr = 5'd9; wdata = 32'h0000_AAAA;
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_value("reset_async_rdata_a", rdata_a, 32'h0);
    check_value("reset_async_count", {16'h0, wr_count}, 32'h0);
    @(posedge clk);
    #1;
    we = 1'b0;
    #1;
    check_value("reset_write_discarded", rdata_b, 32'h0);
    check_value("reset_write_uncounted", {16'h0, wr_count}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // First write after release commits; basic write/read on both ports.
    step(1'b1, 5'd3, 32'hDEAD_BEEF, 5'd3, 5'd3);
    step(1'b0, 5'd0, 32'h0, 5'd3, 5'd3);
    check_value("basic_count", {16'h0, wr_count}, 32'd1);

    // r0 protection.
    step(1'b1, 5'd0, 32'hFFFF_FFFF, 5'd0, 5'd0);
    step(1'b0, 5'd0, 32'h0, 5'd0, 5'd0);

    // Read during write on r7.
    step(1'b1, 5'd7, 32'h0000_0011, 5'd0, 5'd0);
    step(1'b1, 5'd7, 32'h0000_0022, 5'd7, 5'd7);
    step(1'b0, 5'd0, 32'h0, 5'd7, 5'd7);

    // Dual-port independence and ALUSrc mux input 0.
    step(1'b1, 5'd1, 32'h0000_000A, 5'd0, 5'd0);
    step(1'b1, 5'd2, 32'h0000_000B, 5'd0, 5'd0);
    step(1'b0, 5'd0, 32'h0, 5'd1, 5'd2);
    alu_b = 1'b0 ? 32'hFFFF_FFF0 : rdata_b;
    check_value("alusrc_mux_s0", alu_b, 32'h0000_000B);

    // Drive the 4-bit counter into saturation.
    repeat (20) step(1'b1, 5'd9, $urandom, 5'd9, 5'd0);
    step(1'b0, 5'd0, 32'h0, 5'd9, 5'd9);
    check_value("small_count_saturated", {28'h0, wr_count_s}, 32'd15);

    // Random traffic with frequent read/write address collisions.
    for (int n = 0; n < 200; n++) begin
      wa = 5'($urandom_range(0, 31));
      ra = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 31));
      rb = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 31));
      step(($urandom_range(0, 9) < 7), wa, $urandom, ra, rb);
    end
    step(1'b0, 5'd0, 32'h0, 5'd1, 5'd2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/sc_register_file.md
Name: sc_register_file

Overview:
- Architectural register file for the single-cycle processor (SCP) datapath.
- Read port A drives the ALU A operand directly.
- Read port B feeds the ALU-source 2x1 multiplexer (mux input 0; sign-extended immediate on input 1).
- Write port is driven by the write-back stage. Provides a committed-write counter for lab instrumentation.

Parameters:
- DATA_W, 32, register data width in bits
- ADDR_W, 5, register address width
- NUM_REGS, 32, number of architectural registers; must equal 2**ADDR_W
- CNT_W, 16, width of committed-write counter

Ports:
- clk  input  1  system clock; all state updates on rising edge
- rst_n  input  1  asynchronous active-low reset
- we  input  1  write enable from control unit (RegWrite)
- waddr  input  ADDR_W  destination register index
- wdata  input  DATA_W  write-back data
- raddr_a  input  ADDR_W  source register A index (rs)
- raddr_b  input  ADDR_W  source register B index (rt)
- rdata_a  output  DATA_W  register A contents (to ALU)
- rdata_b  output  DATA_W  register B contents (to ALUSrc mux input 0)
- wr_count  output  CNT_W  number of committed writes since reset, saturating

Behaviour:
- Reset (rst_n low, asynchronous): all NUM_REGS registers clear to 0, and wr_count clears to 0.
  - Consequently rdata_a = rdata_b = 0 while reset is held.
  - Reset takes effect immediately, without waiting for clk.
- A write request sampled at a rising edge while rst_n is low is discarded.
- Deassertion is also asynchronous. The first write can commit on the first rising edge with rst_n high.
- Write: on rising clk, if we=1 and waddr!=0, reg[waddr] <= wdata. The write is visible on the read ports from the following cycle, so write latency is 1 cycle.
- Register 0 is hardwired to zero:
  - A write to waddr=0 is ignored and does not change storage.
  - A read of index 0 always returns 0, in all configurations.
- Reads are combinational (0-cycle latency): rdata_x = reg[raddr_x] and changes within the same cycle as raddr_x.
- Both read ports may address the same register; both return identical data.
- Read-during-write (raddr_x == waddr, we=1, waddr!=0, same cycle): the default returns the OLD stored value (read-before-write). See Optional Feature.
- wr_count increments by 1 on each rising edge where a write commits (we=1, waddr!=0, rst_n=1).
  - It holds at 2**CNT_W-1 and does not wrap.
  - Writes to r0 are not counted.
- Addresses are always in range (NUM_REGS = 2**ADDR_W), so there is no out-of-range case.
- X on we while rst_n=1 is a bench error and is not handled.

Optional Feature:
- Macro: SC_REGFILE_BYPASS_EN.
- Defined:
  - Write-through bypass. When we=1, waddr!=0 and raddr_x==waddr, rdata_x = wdata combinationally in the same cycle.
  - Each port bypasses independently.
  - Index 0 still reads 0.
- Undefined: read-before-write as above; no bypass logic is synthesised.
- Storage, reset and wr_count behaviour are identical in both builds.

Decomposition:
- Shared package sc_pkg holds:
  - DATA_W and ADDR_W constants, shared with the ALU and the ALUSrc mux
  - typedef reg_addr_t (ADDR_W bits), typedef word_t (DATA_W bits)
  - constant REG_ZERO = 0
- One sub-module is natural: sc_regfile_read_port, instantiated twice. It performs the index, zero-forcing and optional bypass for one read port.
- Storage and wr_count stay in the top module.

Test Plan:
- Reset: preload r5=0x1234 via write, pulse rst_n low mid-cycle -> rdata for raddr_a=5 becomes 0 immediately (before next clk edge); wr_count=0.
- Basic write/read: we=1, waddr=3, wdata=0xDEADBEEF at edge N -> at cycle N+1, raddr_a=3 gives 0xDEADBEEF, raddr_b=3 gives 0xDEADBEEF; wr_count=1.
- r0 protection: we=1, waddr=0, wdata=0xFFFFFFFF -> raddr_a=0 reads 0; wr_count unchanged.
- Read-during-write: r7=0x11; in the same cycle we=1, waddr=7, wdata=0x22, raddr_b=7 -> rdata_b is 0x11 (default) or 0x22 (SC_REGFILE_BYPASS_EN). In the next cycle rdata_b is 0x22 in both builds.
- Dual-port independence: r1=0xA, r2=0xB -> raddr_a=1, raddr_b=2 gives rdata_a=0xA, rdata_b=0xB. Feed rdata_b into the ALUSrc mux with S=0 -> mux output 0xB.
- Counter saturation (CNT_W=4 override): 20 writes to r9 -> wr_count stops at 15. A write asserted while rst_n=0 is not committed.
